// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if -- signal bundle between decode/write-back and the ID/EX
// pipeline register.
//   Decode side   : id_valid, id_rs/id_rt/id_rd, id_rdata1/2, id_imm, id_ctrl
//   Write-back    : wb_we, wb_rd, wb_data (same values written to the RF)
//   Execute ctrl  : ex_busy, flush
//   Stage outputs : ex_valid, ex_rs/ex_rt/ex_rd, ex_a, ex_b, ex_imm, ex_ctrl,
//                   id_stall, stage_state, bubble_count
// master: the surrounding pipeline, which drives the inputs.
// slave : the id_ex_stage register itself.
interface id_ex_stage_if;
    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [31:0] id_rdata1;
    logic [31:0] id_rdata2;
    logic [31:0] id_imm;
    logic [7:0]  id_ctrl;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_busy;
    logic        flush;

    logic        ex_valid;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [31:0] ex_imm;
    logic [7:0]  ex_ctrl;
    logic        id_stall;
    logic [1:0]  stage_state;
    logic [15:0] bubble_count;

    modport master (
        output id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm,
               id_ctrl, wb_we, wb_rd, wb_data, ex_busy, flush,
        input  ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl,
               id_stall, stage_state, bubble_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm,
               id_ctrl, wb_we, wb_rd, wb_data, ex_busy, flush,
        output ex_valid, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl,
               id_stall, stage_state, bubble_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register with load-use hazard detection,
// write-back bypass into the captured operands, execute back-pressure and
// flush handling.
// Ports:
//   clk2  : clock, all state changes on its rising edge
//   reset : asynchronous, active-low; clears all state
//   bus   : id_ex_stage_if.slave (decode/write-back inputs, ex_* outputs,
//           id_stall, stage_state, bubble_count)
// Per-edge priority: flush > ex_busy > load-use hazard > normal capture.
module id_ex_stage (
    input  logic           clk2,
    input  logic           reset,
    id_ex_stage_if.slave   bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        ex_valid_q, ex_valid_d;
    logic [4:0]  ex_rs_q, ex_rs_d;
    logic [4:0]  ex_rt_q, ex_rt_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [31:0] ex_a_q, ex_a_d;
    logic [31:0] ex_b_q, ex_b_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [7:0]  ex_ctrl_q, ex_ctrl_d;
    logic [15:0] bubble_q, bubble_d;
    logic        hazard;
    logic        stall;
    logic        bypass_a;
    logic        bypass_b;

    // Load in execute whose destination feeds the instruction in decode.
    assign hazard = bus.id_valid & ex_valid_q & ex_ctrl_q[1] & (ex_rd_q != 5'd0) &
                    ((ex_rd_q == bus.id_rs) | (ex_rd_q == bus.id_rt));

    // Register 0 is hard-wired, so a write-back to it is never forwarded.
    assign bypass_a = bus.wb_we & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rs);
    assign bypass_b = bus.wb_we & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rt);

    always_comb begin
        state_d    = RUN;
        stall      = 1'b0;
        ex_valid_d = ex_valid_q;
        ex_rs_d    = ex_rs_q;
        ex_rt_d    = ex_rt_q;
        ex_rd_d    = ex_rd_q;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_imm_d   = ex_imm_q;
        ex_ctrl_d  = ex_ctrl_q;
        bubble_d   = bubble_q;

        if (bus.flush) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            state_d    = RUN;
        end else if (bus.ex_busy) begin
            // Everything holds; operands are not re-bypassed.
            state_d = HOLD;
            stall   = 1'b1;
        end else if (hazard) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            state_d    = BUBBLE;
            stall      = 1'b1;
            if (bubble_q != '1) begin
                bubble_d = bubble_q + 16'd1;
            end
        end else begin
            ex_valid_d = bus.id_valid;
            ex_rs_d    = bus.id_rs;
            ex_rt_d    = bus.id_rt;
            ex_rd_d    = bus.id_rd;
            ex_imm_d   = bus.id_imm;
            ex_ctrl_d  = bus.id_valid ? bus.id_ctrl : '0;
            ex_a_d     = bypass_a ? bus.wb_data : bus.id_rdata1;
            ex_b_d     = bypass_b ? bus.wb_data : bus.id_rdata2;
            state_d    = RUN;
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk2 or negedge reset) begin
        if (!reset) begin
            ex_valid_q <= 1'b0;
            ex_rs_q    <= '0;
            ex_rt_q    <= '0;
            ex_rd_q    <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_imm_q   <= '0;
            ex_ctrl_q  <= '0;
            bubble_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_rs_q    <= ex_rs_d;
            ex_rt_q    <= ex_rt_d;
            ex_rd_q    <= ex_rd_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_imm_q   <= ex_imm_d;
            ex_ctrl_q  <= ex_ctrl_d;
            bubble_q   <= bubble_d;
        end
    end

    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_rs        = ex_rs_q;
    assign bus.ex_rt        = ex_rt_q;
    assign bus.ex_rd        = ex_rd_q;
    assign bus.ex_a         = ex_a_q;
    assign bus.ex_b         = ex_b_q;
    assign bus.ex_imm       = ex_imm_q;
    assign bus.ex_ctrl      = ex_ctrl_q;
    assign bus.stage_state  = state_q;
    assign bus.bubble_count = bubble_q;
    // Stall is suppressed while reset is asserted, even if ex_busy is high.
    assign bus.id_stall     = stall & reset;

endmodule
